// File: rtl/glyph_pkg.sv
// Shared definitions for the glyph ROM and its clients.
//   - GLYPH_AW / GLYPH_DW : glyph ROM address and row-word widths.
//   - CHAR_* : base row address of each glyph (16 rows per glyph).
//   - req_idx_t : requester index, wide enough for up to MAX_NREQ requesters.
//   - next_idx() : round-robin successor of a requester index.
package glyph_pkg;

  localparam int GLYPH_AW = 10;
  localparam int GLYPH_DW = 32;

  localparam int CHAR_WIDTH  = 32;  // pixels per row word
  localparam int CHAR_HEIGHT = 16;  // rows per glyph

  localparam logic [GLYPH_AW-1:0] CHAR_0 = 10'h000;
  localparam logic [GLYPH_AW-1:0] CHAR_1 = 10'h010;
  localparam logic [GLYPH_AW-1:0] CHAR_2 = 10'h020;
  localparam logic [GLYPH_AW-1:0] CHAR_3 = 10'h030;
  localparam logic [GLYPH_AW-1:0] CHAR_4 = 10'h040;
  localparam logic [GLYPH_AW-1:0] CHAR_5 = 10'h050;
  localparam logic [GLYPH_AW-1:0] CHAR_6 = 10'h060;
  localparam logic [GLYPH_AW-1:0] CHAR_7 = 10'h070;
  localparam logic [GLYPH_AW-1:0] CHAR_8 = 10'h080;
  localparam logic [GLYPH_AW-1:0] CHAR_9 = 10'h090;
  localparam logic [GLYPH_AW-1:0] CHAR_a = 10'h0A0;

  localparam int MAX_NREQ  = 8;
  localparam int REQ_IDX_W = 3;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  // Successor of i in a ring of n requesters (n-1 wraps to 0).
  function automatic req_idx_t next_idx(input req_idx_t i, input int unsigned n);
    return (32'(i) == n - 1) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Finds the first asserted request at index ptr, ptr+1, ... wrapping
// modulo NREQ.
//   req    : request vector
//   ptr    : highest-priority index this cycle
//   onehot : one-hot of the chosen requester (0 when none)
//   idx    : index of the chosen requester (0 when none)
//   any    : at least one request asserted
module rr_pick
  import glyph_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  req_idx_t        ptr,
  output logic [NREQ-1:0] onehot,
  output req_idx_t        idx,
  output logic            any
);

  // Two passes avoid a modulo index: first the indices at or above ptr,
  // then the ones below it that the wrap brings round.
  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no
    // path leaves a value unassigned and no latch is inferred.
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        any       = 1'b1;
        idx       = req_idx_t'(i);
        onehot[i] = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (i < int'(ptr))) begin
        any       = 1'b1;
        idx       = req_idx_t'(i);
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/glyph_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous glyph ROM among NREQ text
// renderers. One grant per cycle; the ROM word comes back to the granted
// requester a fixed RD_LAT+1 edges after its grant, in grant order.
//
// Ports:
//   clk       : pixel clock
//   rst       : asynchronous reset, active low
//   req       : per-requester read request, held until granted
//   req_adr   : packed addresses, slot i at [i*AW +: AW]
//   req_lock  : (GLYPH_ARB_LOCK_EN only) ask to keep the grant next cycle
//   gnt       : registered one-hot grant
//   rom_adr   : registered ROM address
//   rom_data  : ROM read data, valid RD_LAT edges after rom_adr
//   rsp_valid : one-cycle one-hot pulse marking rsp_data's owner
//   rsp_data  : registered copy of rom_data
//
// Build option GLYPH_ARB_LOCK_EN: adds req_lock and MAX_LOCK so a requester
// can hold the ROM for bursts of up to MAX_LOCK back-to-back grants.
module glyph_rom_arbiter
  import glyph_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int AW     = GLYPH_AW,
  parameter int DW     = GLYPH_DW,
  parameter int RD_LAT = 1
`ifdef GLYPH_ARB_LOCK_EN
  ,
  parameter int MAX_LOCK = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] req_adr,
`ifdef GLYPH_ARB_LOCK_EN
  input  logic [NREQ-1:0]  req_lock,
`endif
  output logic [NREQ-1:0]  gnt,
  output logic [AW-1:0]    rom_adr,
  input  logic [DW-1:0]    rom_data,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_data
);

  req_idx_t        ptr;
  req_idx_t        gnt_idx;   // index matching the registered gnt
  logic [NREQ-1:0] pick_oh;
  req_idx_t        pick_idx;
  logic            pick_any;

  logic [NREQ-1:0] sel_oh;
  req_idx_t        sel_idx;
  logic            sel_any;
  req_idx_t        ptr_next;
  logic [AW-1:0]   sel_adr;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifdef GLYPH_ARB_LOCK_EN
  localparam logic [4:0] MAX_LOCK_C = 5'(MAX_LOCK);

  logic [4:0] burst_cnt;  // consecutive grants held by the current owner
  logic       lock_hit;

  // gnt is one-hot of the current owner, so masking with it selects that
  // requester's req and req_lock.
  assign lock_hit = (|(gnt & req & req_lock)) && (burst_cnt < MAX_LOCK_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_cnt <= '0;
    end else if (lock_hit) begin
      burst_cnt <= burst_cnt + 5'd1;
    end else if (pick_any) begin
      burst_cnt <= 5'd1;       // a fresh grant starts a new burst
    end else begin
      burst_cnt <= '0;
    end
  end
`endif

  always_comb begin
    sel_oh   = pick_oh;
    sel_idx  = pick_idx;
    sel_any  = pick_any;
    ptr_next = pick_any ? next_idx(pick_idx, NREQ) : ptr;
`ifdef GLYPH_ARB_LOCK_EN
    // Locked re-grant: keep the owner and leave ptr where it was.
    if (lock_hit) begin
      sel_oh   = gnt;
      sel_idx  = gnt_idx;
      sel_any  = 1'b1;
      ptr_next = ptr;
    end
`endif
    sel_adr = rom_adr;  // no grant: address holds
    for (int i = 0; i < NREQ; i++) begin
      if (sel_oh[i]) sel_adr = req_adr[i*AW +: AW];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      gnt     <= '0;
      rom_adr <= '0;
      ptr     <= '0;
      gnt_idx <= '0;
    end else begin
      gnt     <= sel_oh;
      rom_adr <= sel_adr;
      ptr     <= ptr_next;
      if (sel_any) gnt_idx <= sel_idx;
    end
  end

  // Delay pipe: stage 0 is loaded while rom_adr is being presented; the
  // last stage lines up with rom_data and is turned into the response.
  logic     pipe_v   [RD_LAT];
  req_idx_t pipe_idx [RD_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the pipe array is reset element by element; an unreset valid
      // bit would fire a response for a grant from before reset.
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_idx[i] <= '0;
      end
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      pipe_v[0]   <= |gnt;
      pipe_idx[0] <= gnt_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
      rsp_data <= rom_data;
      for (int i = 0; i < NREQ; i++) begin
        rsp_valid[i] <= pipe_v[RD_LAT-1] && (pipe_idx[RD_LAT-1] == req_idx_t'(i));
      end
    end
  end

endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// Directed bench for glyph_rom_arbiter (NREQ=4). A behavioural ROM with
// TB_RD_LAT read latency returns a distinct word per address. Expected
// grants and addresses come from hand-filled tables; expected responses are
// the expected grants delayed by TB_RD_LAT+1 edges.
// Build option GLYPH_ARB_LOCK_EN adds the burst-lock sequence (MAX_LOCK=4).
module tb_glyph_rom_arbiter;

  localparam int TB_RD_LAT = 1;
  localparam int LAT       = TB_RD_LAT + 1;  // gnt edge -> rsp_valid edge

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [39:0] req_adr;
  logic [3:0]  gnt;
  logic [9:0]  rom_adr;
  logic [31:0] rom_data;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_data;
`ifdef GLYPH_ARB_LOCK_EN
  logic [3:0]  req_lock;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] gnt_hist[$];
  logic [9:0] adr_hist[$];

  glyph_rom_arbiter #(
    .NREQ   (4),
    .AW     (10),
    .DW     (32),
    .RD_LAT (TB_RD_LAT)
`ifdef GLYPH_ARB_LOCK_EN
    , .MAX_LOCK (4)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_adr   (req_adr),
`ifdef GLYPH_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .gnt       (gnt),
    .rom_adr   (rom_adr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slot 0 = 040, 1 = 123, 2 = 2A0, 3 = 3FF.
  assign req_adr = {10'h3FF, 10'h2A0, 10'h123, 10'h040};

  function automatic logic [31:0] rom_fn(input logic [9:0] a);
    return {6'h2A, a, 6'h15, a};
  endfunction

  logic [31:0] rom_pipe [TB_RD_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_fn(rom_adr);
    for (int i = 1; i < TB_RD_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[TB_RD_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Asserts reset mid-cycle, checks outputs clear at once, releases it away
  // from the clock edge and restarts the expected-response history.
  task automatic do_reset(input string name);
    req = '0;
`ifdef GLYPH_ARB_LOCK_EN
    req_lock = '0;
`endif
    #3 rst = 1'b0;
    #1;
    check({name, " gnt"},       32'(gnt),       32'h0);
    check({name, " rom_adr"},   32'(rom_adr),   32'h0);
    check({name, " rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({name, " rsp_data"},  rsp_data,       32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    gnt_hist.delete();
    adr_hist.delete();
    for (int i = 0; i < LAT; i++) begin
      gnt_hist.push_back(4'b0000);
      adr_hist.push_back(10'h000);
    end
  endtask

  // One clock: drive req, then check gnt/rom_adr and the response due now.
  task automatic apply(input string name, input logic [3:0] r,
                       input logic [3:0] exp_gnt, input logic [9:0] exp_adr);
    int k;
    req = r;
    @(posedge clk);
    #1;
    check({name, " gnt"},     32'(gnt),     32'(exp_gnt));
    check({name, " rom_adr"}, 32'(rom_adr), 32'(exp_adr));
    gnt_hist.push_back(exp_gnt);
    adr_hist.push_back(exp_adr);
    k = gnt_hist.size() - 1 - LAT;
    check({name, " rsp_valid"}, 32'(rsp_valid), 32'(gnt_hist[k]));
    if (gnt_hist[k] != 4'b0000)
      check({name, " rsp_data"}, rsp_data, rom_fn(adr_hist[k]));
  endtask

  typedef struct packed {
    logic       rst;   // pulse reset before this vector
    logic [3:0] req;
    logic [3:0] gnt;
    logic [9:0] adr;
  } vec_t;

  vec_t tbl [23];

  initial begin
    // single request, response two edges after the grant
    tbl[0]  = '{1'b1, 4'b0001, 4'b0001, 10'h040};
    tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 10'h040};
    tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 10'h040};
    // all four held: each granted once every four cycles
    tbl[3]  = '{1'b1, 4'b1111, 4'b0001, 10'h040};
    tbl[4]  = '{1'b0, 4'b1111, 4'b0010, 10'h123};
    tbl[5]  = '{1'b0, 4'b1111, 4'b0100, 10'h2A0};
    tbl[6]  = '{1'b0, 4'b1111, 4'b1000, 10'h3FF};
    tbl[7]  = '{1'b0, 4'b1111, 4'b0001, 10'h040};
    tbl[8]  = '{1'b0, 4'b1111, 4'b0010, 10'h123};
    tbl[9]  = '{1'b0, 4'b1111, 4'b0100, 10'h2A0};
    tbl[10] = '{1'b0, 4'b1111, 4'b1000, 10'h3FF};
    // move ptr to 2, then 0011 wraps round to requester 0 first
    tbl[11] = '{1'b0, 4'b0010, 4'b0010, 10'h123};
    tbl[12] = '{1'b0, 4'b0011, 4'b0001, 10'h040};
    tbl[13] = '{1'b0, 4'b0011, 4'b0010, 10'h123};
    tbl[14] = '{1'b0, 4'b0000, 4'b0000, 10'h123};
    tbl[15] = '{1'b0, 4'b0000, 4'b0000, 10'h123};
    tbl[16] = '{1'b0, 4'b0000, 4'b0000, 10'h123};
    // ptr=2: 0101 grants 2; requester 0 drops before its turn, no response
    tbl[17] = '{1'b0, 4'b0101, 4'b0100, 10'h2A0};
    tbl[18] = '{1'b0, 4'b0000, 4'b0000, 10'h2A0};
    tbl[19] = '{1'b0, 4'b0000, 4'b0000, 10'h2A0};
    // top index, ptr wraps from 3 back to 0
    tbl[20] = '{1'b0, 4'b1000, 4'b1000, 10'h3FF};
    tbl[21] = '{1'b0, 4'b0000, 4'b0000, 10'h3FF};
    tbl[22] = '{1'b0, 4'b0000, 4'b0000, 10'h3FF};

    rst = 1'b1;
    req = '0;
`ifdef GLYPH_ARB_LOCK_EN
    req_lock = '0;
`endif

    for (int i = 0; i < 23; i++) begin
      if (tbl[i].rst) do_reset($sformatf("v%0d reset", i));
      apply($sformatf("v%0d", i), tbl[i].req, tbl[i].gnt, tbl[i].adr);
    end

    // Mid-stream reset with two grants in flight (ptr left at 2).
    do_reset("pre-mid reset");
    apply("mid a", 4'b0001, 4'b0001, 10'h040);
    apply("mid b", 4'b1111, 4'b0010, 10'h123);
    do_reset("mid reset");
    for (int i = 0; i < 4; i++)
      apply($sformatf("post rst idle%0d", i), 4'b0000, 4'b0000, 10'h000);
    // ptr cleared by reset: requester 0 wins again
    apply("post rst g", 4'b1111, 4'b0001, 10'h040);
    apply("post rst d0", 4'b0000, 4'b0000, 10'h040);
    apply("post rst d1", 4'b0000, 4'b0000, 10'h040);

`ifdef GLYPH_ARB_LOCK_EN
    // Requester 0 locks: four grants, forced round-robin, then locks again.
    do_reset("lock reset");
    req_lock = 4'b0001;
    for (int i = 0; i < 4; i++)
      apply($sformatf("lock burst%0d", i), 4'b1111, 4'b0001, 10'h040);
    apply("lock rr1", 4'b1111, 4'b0010, 10'h123);
    apply("lock rr2", 4'b1111, 4'b0100, 10'h2A0);
    apply("lock rr3", 4'b1111, 4'b1000, 10'h3FF);
    apply("lock again", 4'b1111, 4'b0001, 10'h040);
    req_lock = 4'b0000;
    apply("lock drain0", 4'b0000, 4'b0000, 10'h040);
    apply("lock drain1", 4'b0000, 4'b0000, 10'h040);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
